// File: rtl/dtree_pkg.sv
// ============================================================================
// Module  : dtree_pkg
// Purpose : Shared definitions for the decision-tree inference controller:
//           FSM state encoding, default frame geometry and the mapping from
//           feature-buffer slot to tree input index.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dtree_pkg;

    // Default frame geometry
    localparam int unsigned c_N_FEAT_DEF = 18;
    localparam int unsigned c_FEAT_W_DEF = 8;
    localparam int unsigned c_CLS_W_DEF  = 2;

    // Controller states
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Slot k feeds tree input X<n>. Inputs X4 and X5 are not used by the
    // trained tree, so slots 4.. skip over them (X0..X3, X6..X19).
    function automatic int unsigned slot_to_feat(input int unsigned k);
        return (k < 4) ? k : k + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dtree_feat_buf.sv
// ============================================================================
// Module  : dtree_feat_buf
// Purpose : N_FEAT-slot feature register. One slot is written per enabled
//           cycle; all slots are presented in parallel to the tree.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           i_we            - write enable for slot i_idx
//           i_idx           - slot index to write
//           i_data          - feature byte
//           o_feat_bus      - all slots, slot k at [k*FEAT_W +: FEAT_W]
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dtree_feat_buf
    import dtree_pkg::*;
#(
    parameter int unsigned N_FEAT = c_N_FEAT_DEF,
    parameter int unsigned FEAT_W = c_FEAT_W_DEF,
    parameter int unsigned IDX_W  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_we,
    input  logic [IDX_W-1:0]           i_idx,
    input  logic [FEAT_W-1:0]          i_data,
    output logic [N_FEAT*FEAT_W-1:0]   o_feat_bus
);

    for (genvar k = 0; k < N_FEAT; k++) begin : g_slot
        logic [FEAT_W-1:0] r_slot;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_slot <= '0;
            end else if (i_we && (i_idx == IDX_W'(k))) begin
                r_slot <= i_data;
            end
        end

        assign o_feat_bus[k*FEAT_W +: FEAT_W] = r_slot;
    end

endmodule

`default_nettype wire

// File: rtl/dtree_infer_ctrl.sv
// ============================================================================
// Module  : dtree_infer_ctrl
// Purpose : Collects a frame of N_FEAT feature bytes, lets an external
//           combinational decision tree settle for EVAL_CYCLES cycles,
//           captures its class and holds it until the consumer accepts it.
// Ports   : clk, rst_n            - clock, asynchronous active-low reset
//           in_valid/in_ready     - feature byte handshake, in_data payload
//           abort                 - discard current frame (ignored in DONE)
//           feat_bus              - registered features to the tree
//           tree_class            - combinational tree result
//           out_valid/out_ready   - result handshake, out_class payload
//           busy                  - high unless idle at slot 0 in LOAD
//           infer_cnt             - completed-inference count (optional)
// Config  : define DTREE_INFER_CNT_EN to add the saturating 16-bit
//           infer_cnt output.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dtree_infer_ctrl
    import dtree_pkg::*;
#(
    parameter int unsigned N_FEAT      = c_N_FEAT_DEF,
    parameter int unsigned FEAT_W      = c_FEAT_W_DEF,
    parameter int unsigned CLS_W       = c_CLS_W_DEF,
    parameter int unsigned EVAL_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FEAT_W-1:0]          in_data,
    input  logic                       abort,
    output logic [N_FEAT*FEAT_W-1:0]   feat_bus,
    input  logic [CLS_W-1:0]           tree_class,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CLS_W-1:0]           out_class,
    output logic                       busy
`ifdef DTREE_INFER_CNT_EN
    ,
    output logic [15:0]                infer_cnt
`endif
);

    localparam int unsigned        c_IDX_W     = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(N_FEAT - 1);
    localparam logic [3:0]         c_WCNT_LAST = 4'(EVAL_CYCLES - 1);

    state_t             r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [3:0]         r_wcnt;
    logic [CLS_W-1:0]   r_out_class;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               r_busy;
    logic               w_accept;

    // A byte is taken only while loading; abort wins over a same-cycle byte.
    assign w_accept = r_in_ready & in_valid & ~abort;

    dtree_feat_buf #(
        .N_FEAT (N_FEAT),
        .FEAT_W (FEAT_W),
        .IDX_W  (c_IDX_W)
    ) u_feat_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_accept),
        .i_idx      (r_idx),
        .i_data     (in_data),
        .o_feat_bus (feat_bus)
    );

    // Control FSM. Handshake outputs are registered alongside the state so
    // that they always reflect the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_idx       <= '0;
            r_wcnt      <= '0;
            r_out_class <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (abort) begin
                        r_idx  <= '0;
                        r_busy <= 1'b0;
                    end else if (in_valid) begin
                        if (r_idx == c_IDX_LAST) begin
                            r_idx      <= '0;
                            r_wcnt     <= '0;
                            r_state    <= ST_EVAL;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_idx  <= r_idx + c_IDX_W'(1);
                            r_busy <= 1'b1;
                        end
                    end
                end

                ST_EVAL: begin
                    if (abort) begin
                        r_wcnt     <= '0;
                        r_state    <= ST_LOAD;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else if (r_wcnt == c_WCNT_LAST) begin
                        // Tree has had EVAL_CYCLES full cycles to settle.
                        r_out_class <= tree_class;
                        r_out_valid <= 1'b1;
                        r_wcnt      <= '0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_wcnt <= r_wcnt + 4'd1;
                    end
                end

                ST_DONE: begin
                    // No byte is accepted in the release cycle; the next
                    // frame starts one cycle after out_ready.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_LOAD;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= ST_LOAD;
                    r_idx       <= '0;
                    r_wcnt      <= '0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_class = r_out_class;
    assign busy      = r_busy;

`ifdef DTREE_INFER_CNT_EN
    logic [15:0] r_infer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_infer_cnt <= '0;
        end else if (r_out_valid && out_ready && (r_infer_cnt != 16'hFFFF)) begin
            r_infer_cnt <= r_infer_cnt + 16'd1;
        end
    end

    assign infer_cnt = r_infer_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dtree_infer_ctrl.sv
// ============================================================================
// Module  : tb_dtree_infer_ctrl
// Purpose : Self-checking bench for dtree_infer_ctrl: table-driven frames,
//           hand-written handshake/abort/reset sequences and randomized
//           frames compared against a frame-level reference model.
// Config  : DTREE_INFER_CNT_EN adds the infer_cnt connection and check.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dtree_infer_ctrl;

    localparam int NF = 18;
    localparam int FW = 8;
    localparam int CW = 2;
    localparam int EC = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [FW-1:0]     in_data;
    logic              abort;
    logic [NF*FW-1:0]  feat_bus;
    logic [CW-1:0]     tree_class;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_class;
    logic              busy;
`ifdef DTREE_INFER_CNT_EN
    logic [15:0]       infer_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    // Tree stub: either a constant class or a small decision tree over the
    // presented features.
    logic          stub_en;
    logic [CW-1:0] stub_val;

    function automatic logic [1:0] tree_fn(input logic [NF*FW-1:0] fb);
        logic [7:0] x [NF];
        for (int k = 0; k < NF; k++) x[k] = fb[k*FW +: FW];
        if (x[0] < 8'h80) begin
            if (x[4] > x[9]) return 2'd0;
            else             return 2'd1;
        end else begin
            if (x[17][0])    return 2'd2;
            else             return 2'd3;
        end
    endfunction

    always_comb tree_class = stub_en ? stub_val : tree_fn(feat_bus);

    always #5 clk = ~clk;

    dtree_infer_ctrl #(
        .N_FEAT      (NF),
        .FEAT_W      (FW),
        .CLS_W       (CW),
        .EVAL_CYCLES (EC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .abort      (abort),
        .feat_bus   (feat_bus),
        .tree_class (tree_class),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .busy       (busy)
`ifdef DTREE_INFER_CNT_EN
        ,
        .infer_cnt  (infer_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one byte at a negedge; it is accepted at the next posedge.
    // Returns at the following negedge with in_valid low.
    task automatic send_byte(input logic [7:0] d);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts cycles from the cycle after the last accepted byte (lat=1).
    task automatic wait_out_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_done++;
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int k = 0; k < NF; k++) send_byte(base + 8'(k));
    endtask

    typedef struct {
        logic [1:0] stub;
        logic [7:0] base;
        logic [1:0] exp_class;
        int         exp_lat;
        logic [7:0] exp_s5;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int             lat;
        logic [NF*FW-1:0] snap;
        logic [7:0]     bytes [NF];
        logic [NF*FW-1:0] ev;
        int             n;
        logic           seen;

        vecs[0] = '{2'b10, 8'h00, 2'b10, EC + 1, 8'h05};
        vecs[1] = '{2'b01, 8'h30, 2'b01, EC + 1, 8'h35};
        vecs[2] = '{2'b11, 8'hF0, 2'b11, EC + 1, 8'hF5};
        vecs[3] = '{2'b00, 8'h7A, 2'b00, EC + 1, 8'h7F};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0;
        out_ready = 1'b0; stub_en = 1'b1; stub_val = 2'b10;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_feat_bus", feat_bus, 0);
        chk("rst_out_class", out_class, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Table-driven continuous frames
        for (int i = 0; i < 4; i++) begin
            stub_val = vecs[i].stub;
            send_frame(vecs[i].base);
            wait_out_valid(lat);
            chk("vec_latency", lat, vecs[i].exp_lat);
            chk("vec_class", out_class, vecs[i].exp_class);
            chk("vec_slot5", feat_bus[5*FW +: FW], vecs[i].exp_s5);
            chk("vec_in_ready_done", in_ready, 0);
            chk("vec_busy_done", busy, 1);
            consume();
            chk("vec_in_ready_after", in_ready, 1);
            chk("vec_out_valid_after", out_valid, 0);
            chk("vec_busy_after", busy, 0);
        end

        // DONE held for 10 cycles, abort and bytes in DONE ignored
        stub_val = 2'b01;
        send_frame(8'h20);
        wait_out_valid(lat);
        snap = feat_bus;
        for (int c = 0; c < 10; c++) begin
            abort    = (c == 5);
            in_valid = (c == 5);
            in_data  = 8'hAA;
            @(negedge clk);
            abort    = 1'b0;
            in_valid = 1'b0;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_class", out_class, 2'b01);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_feat_bus", feat_bus, snap);
        end
        consume();
        chk("hold_release_in_ready", in_ready, 1);
        chk("hold_release_out_valid", out_valid, 0);

        // Abort after 7 bytes (with a byte offered in the abort cycle)
        stub_val = 2'b11;
        for (int k = 0; k < 7; k++) send_byte(8'h90 + 8'(k));
        abort = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy_clear", busy, 0);
        chk("abort_no_result", out_valid, 0);
        send_frame(8'h40);
        wait_out_valid(lat);
        chk("abort_latency", lat, EC + 1);
        chk("abort_slot0", feat_bus[0 +: FW], 8'h40);
        chk("abort_slot17", feat_bus[17*FW +: FW], 8'h51);
        consume();
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_single_result", seen, 0);

        // Abort during EVAL: back to LOAD, no result
        send_frame(8'h60);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("eval_abort_in_ready", in_ready, 1);
        chk("eval_abort_busy", busy, 0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("eval_abort_no_result", seen, 0);

        // Reset asserted during EVAL
        send_frame(8'h10);
        rst_n = 1'b0;
        #1;
        chk("eval_rst_out_valid", out_valid, 0);
        chk("eval_rst_busy", busy, 0);
        chk("eval_rst_feat_bus", feat_bus, 0);
        chk("eval_rst_out_class", out_class, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("eval_rst_no_result", seen, 0);
        chk("eval_rst_in_ready", in_ready, 1);

        // Random frames with gaps and occasional aborts
        stub_en = 1'b0;
        for (int f = 0; f < 100; f++) begin
            n = 0;
            while (n < NF) begin
                if ($urandom_range(1, 0) == 1) begin
                    repeat ($urandom_range(3, 1)) begin
                        in_data = 8'($urandom);
                        @(negedge clk);
                    end
                end
                if ($urandom_range(39, 0) == 0) begin
                    abort = 1'b1; in_valid = 1'($urandom_range(1, 0));
                    in_data = 8'($urandom);
                    @(negedge clk);
                    abort = 1'b0; in_valid = 1'b0;
                    n = 0;
                end
                bytes[n] = 8'($urandom);
                send_byte(bytes[n]);
                n++;
            end
            for (int k = 0; k < NF; k++) ev[k*FW +: FW] = bytes[k];
            wait_out_valid(lat);
            chk("rnd_latency", lat, EC + 1);
            chk("rnd_feat_bus", feat_bus, ev);
            chk("rnd_class", out_class, tree_fn(ev));
            repeat ($urandom_range(3, 0)) @(negedge clk);
            consume();
            chk("rnd_out_valid_after", out_valid, 0);
        end

`ifdef DTREE_INFER_CNT_EN
        chk("infer_cnt", infer_cnt, 16'(n_done));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
